// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter is sized for the widest legal operand so one width serves every W.
  localparam int unsigned W_MAX = 32;
  localparam int unsigned CNT_W = $clog2(W_MAX);

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// SERIAL_ADDER_SUB_EN adds the 'sub' operand qualifier.
interface serial_adder_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/fa_bit_slice.sv
// One full-adder bit slice built from two half adders and a carry OR.
module fa_bit_slice (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.a(x),  .b(y),  .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  assign co = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice sequenced LSB first over W cycles.
// Build with SERIAL_ADDER_SUB_EN to add two's-complement subtraction via bus.sub.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus,
  output logic                 busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     sum_sh_q, sum_sh_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             s_bit;
  logic             c_bit;
  logic [W-1:0]     b_load;
  logic             cin_load;

  // Operand conditioning at load: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = bus.sub ? ~bus.b : bus.b;
  assign cin_load = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_load   = bus.b;
  assign cin_load = bus.cin;
`endif

  fa_bit_slice u_fa (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;

    unique case (state_q)
      IDLE: begin
        // in_ready_q is low on the first edge after reset, so no accept there.
        if (bus.in_valid && in_ready_q) begin
          a_sh_d  = bus.a;
          b_sh_d  = b_load;
          carry_d = cin_load;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d  = c_bit;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {s_bit, sum_sh_q[W-1:1]};
        if (count_q == CNT_W'(W - 1)) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_sh_q;
  assign bus.cout      = carry_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized-backpressure bench for serial_adder_ctrl (W=8).
module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_adder_ctrl_if #(.W(W)) bus ();

  serial_adder_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Ticks until out_valid, bounded; the final check flags a timeout.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 40);
    check_eq(tag, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [8:0]  g;
    logic [7:0]  ra, rb;
    logic        rc;
    int          tries;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'hAA;
    bus.b         = 8'h55;
    bus.cin       = 1'b1;
    bus.out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    repeat (2) tick();
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_sum",       32'(bus.sum),       32'd0);
    check_eq("rst_cout",      32'(bus.cout),      32'd0);
    check_eq("rst_busy",      32'(busy),          32'd0);

    // in_valid already high when reset releases: must not be accepted
    rst_n = 1'b1;
    tick();
    check_eq("rel_noaccept_busy", 32'(busy),         32'd0);
    check_eq("rel_in_ready",      32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check_eq("rel_idle_busy", 32'(busy), 32'd0);

    // 0xFF + 0x01: latency, wraparound, one-cycle DONE
    start_op(8'hFF, 8'h01, 1'b0);
    check_eq("t1_busy",     32'(busy),         32'd1);
    check_eq("t1_in_ready", 32'(bus.in_ready), 32'd0);
    wait_valid("t1_valid", lat);
    check_eq("t1_latency", 32'(lat),      32'd8);
    check_eq("t1_sum",     32'(bus.sum),  32'h00);
    check_eq("t1_cout",    32'(bus.cout), 32'd1);
    tick();
    check_eq("t1_done_1cyc", 32'(bus.out_valid), 32'd0);
    check_eq("t1_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("t1_hold_sum",  32'(bus.sum),       32'h00);
    check_eq("t1_hold_cout", 32'(bus.cout),      32'd1);

    // 0x3C + 0x55 + 1 with 5 cycles of backpressure
    bus.out_ready = 1'b0;
    start_op(8'h3C, 8'h55, 1'b1);
    wait_valid("t2_valid", lat);
    check_eq("t2_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_bp_valid",    32'(bus.out_valid), 32'd1);
      check_eq("t2_bp_sum",      32'(bus.sum),       32'h92);
      check_eq("t2_bp_cout",     32'(bus.cout),      32'd0);
      check_eq("t2_bp_in_ready", 32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("t2_released", 32'(bus.out_valid), 32'd0);

    // New operands offered during RUN are ignored
    start_op(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.a        = 8'hFF;
      bus.b        = 8'hFF;
      bus.cin      = 1'b1;
      bus.in_valid = (i % 2 == 0);
      check_eq("t3_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_valid("t3_valid", lat);
    check_eq("t3_sum",  32'(bus.sum),  32'h46);
    check_eq("t3_cout", 32'(bus.cout), 32'd0);
    tick();

    // Asynchronous reset while RUN count == 3
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t4_async_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t4_async_sum",   32'(bus.sum),       32'd0);
    check_eq("t4_async_busy",  32'(busy),          32'd0);
    check_eq("t4_async_rdy",   32'(bus.in_ready),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t4_rdy_after", 32'(bus.in_ready), 32'd1);
    start_op(8'h10, 8'h20, 1'b0);
    wait_valid("t4_valid", lat);
    check_eq("t4_latency", 32'(lat),      32'd8);
    check_eq("t4_sum",     32'(bus.sum),  32'h30);
    check_eq("t4_cout",    32'(bus.cout), 32'd0);
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b1;
    start_op(8'h05, 8'h07, 1'b0);
    wait_valid("sub1_valid", lat);
    check_eq("sub1_sum",  32'(bus.sum),  32'hFE);
    check_eq("sub1_cout", 32'(bus.cout), 32'd0);
    tick();
    start_op(8'h07, 8'h05, 1'b0);
    wait_valid("sub2_valid", lat);
    check_eq("sub2_sum",  32'(bus.sum),  32'h02);
    check_eq("sub2_cout", 32'(bus.cout), 32'd1);
    tick();
    bus.sub = 1'b0;
`endif

    // Random operands with idle gaps and random consumer backpressure
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      g  = 9'(ra) + 9'(rb) + 9'(rc);
      bus.out_ready = 1'b0;
      check_eq("rnd_in_ready", 32'(bus.in_ready), 32'd1);
      start_op(ra, rb, rc);
      wait_valid("rnd_valid", lat);
      check_eq("rnd_sum",  32'(bus.sum),  32'(g[7:0]));
      check_eq("rnd_cout", 32'(bus.cout), 32'(g[8]));
      tries = 0;
      do begin
        bus.out_ready = (tries > 8) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        tries++;
      end while (bus.out_valid && tries < 20);
      check_eq("rnd_handshake", 32'(bus.out_valid), 32'd0);
      check_eq("rnd_hold_sum",  32'(bus.sum),       32'(g[7:0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
